// File: rtl/uart_block_receiver.sv
// +------------------------------------------------------------------------------+
// | uart_block_receiver: 8N1 UART deserialiser packing bytes MSB-first into a     |
// | SHA-256 message block, handed off with a start pulse. Rev 1.0                 |
// +------------------------------------------------------------------------------+
`default_nettype none

module uart_block_receiver #(
  parameter int CLKS_PER_BIT = 87,
  parameter int NUM_BYTES    = 64,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_uart_rx,
  input  logic                           i_release,
  output logic [8*NUM_BYTES-1:0]         o_block,
  output logic                           o_sha_start,
  output logic                           o_busy,
  output logic [$clog2(NUM_BYTES+1)-1:0] o_byte_count,
  output logic                           o_frame_err,
  output logic                           o_overrun,
  output logic                           o_timeout
);

  localparam int C_HALF      = CLKS_PER_BIT / 2;
  localparam int C_CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int C_IDX_W     = $clog2(NUM_BYTES + 1);
  localparam int C_BLK_W     = 8 * NUM_BYTES;
  localparam int C_LSB_W     = $clog2(C_BLK_W);
  localparam int C_TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int C_TMO_W     = $clog2(C_TMO_LIMIT + 1);

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;
  typedef enum logic [0:0] {BLK_COLLECT = 1'b0, BLK_WAIT = 1'b1} blk_state_t;

  rx_state_t  r_rx_state, w_rx_next;
  blk_state_t r_blk_state, w_blk_next;

  logic               r_rx_meta, r_rx_sync;
  logic [C_CNT_W-1:0] r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_byte_valid;
  logic [C_IDX_W-1:0] r_idx;
  logic [C_TMO_W-1:0] r_tmo_cnt;

  logic w_half_hit, w_full_hit, w_start_det;
  logic w_store, w_full, w_overrun, w_release, w_tmo_active, w_tmo_fire;
  logic [C_LSB_W-1:0] w_wr_lsb;

  assign w_half_hit = (r_clk_cnt == C_CNT_W'(C_HALF - 1));
  assign w_full_hit = (r_clk_cnt == C_CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next   = r_rx_state;
    w_start_det = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (!r_rx_sync) begin
                  w_rx_next   = RX_START;
                  w_start_det = 1'b1;
                end
      RX_START: if (w_half_hit) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full_hit && (r_bit_idx == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:  if (w_full_hit) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // Start phase counts to mid-bit; later phases count whole bit periods from there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= (r_rx_state == RX_STOP) && w_full_hit && r_rx_sync;
      o_frame_err  <= (r_rx_state == RX_STOP) && w_full_hit && !r_rx_sync;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          if (w_start_det) r_bit_idx <= '0;
        end
        RX_START: r_clk_cnt <= w_half_hit ? '0 : r_clk_cnt + 1'b1;
        default: begin
          r_clk_cnt <= w_full_hit ? '0 : r_clk_cnt + 1'b1;
          if ((r_rx_state == RX_DATA) && w_full_hit) begin
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
      endcase
    end
  end

  assign w_tmo_active = (r_blk_state == BLK_COLLECT) && (r_idx != '0);
  assign w_wr_lsb     = C_LSB_W'(C_BLK_W - 8 - 8 * int'(r_idx));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_blk_state <= BLK_COLLECT;
    else     r_blk_state <= w_blk_next;
  end

  always_comb begin
    w_blk_next = r_blk_state;
    w_store    = 1'b0;
    w_full     = 1'b0;
    w_overrun  = 1'b0;
    w_release  = 1'b0;
    w_tmo_fire = 1'b0;
    case (r_blk_state)
      BLK_COLLECT: begin
        if (r_byte_valid) begin
          w_store = 1'b1;
          if (r_idx == C_IDX_W'(NUM_BYTES - 1)) begin
            w_full     = 1'b1;
            w_blk_next = BLK_WAIT;
          end
        end else if (w_tmo_active && (r_rx_state == RX_IDLE) &&
                     (r_tmo_cnt == C_TMO_W'(C_TMO_LIMIT - 1))) begin
          w_tmo_fire = 1'b1;
        end
      end
      BLK_WAIT: begin
        w_overrun = r_byte_valid;
        if (i_release) begin
          w_blk_next = BLK_COLLECT;
          w_release  = 1'b1;
        end
      end
      default: w_blk_next = BLK_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_block     <= '0;
      r_idx       <= '0;
      r_tmo_cnt   <= '0;
      o_sha_start <= 1'b0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_sha_start <= w_full;
      o_overrun   <= w_overrun;
      o_timeout   <= w_tmo_fire;
      o_busy      <= (w_blk_next == BLK_WAIT);
      if (w_store) begin
        o_block[w_wr_lsb +: 8] <= r_shift;
        r_idx                  <= r_idx + 1'b1;
      end else if (w_tmo_fire || w_release) begin
        r_idx <= '0;
      end
      // Idle time only accumulates between frames of a partial block.
      if (!w_tmo_active || w_start_det || w_tmo_fire) r_tmo_cnt <= '0;
      else if (r_rx_state == RX_IDLE)                 r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign o_byte_count = r_idx;

endmodule

`default_nettype wire
